// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
//
// Purpose:
//   Bundles the request and response handshakes around the shared ALU
//   arbiter. Requesters A and B each present one operation (two operands and
//   a 3-bit opcode) under valid/ready. The single response port carries the
//   registered result back together with the id of the requester that owns it.
//
// Signals:
//   A_Valid / A_Ready              request handshake, requester A
//   A_SrcA, A_SrcB                 operands, requester A (DATA_WIDTH bits)
//   A_ALU_Control                  opcode, requester A (3 bits)
//   B_*                            the same set for requester B
//   Rsp_Valid / Rsp_Ready          response handshake
//   Rsp_Id                         owner of the response: 0 = A, 1 = B
//   Rsp_Result, Rsp_Zero           registered ALU result and zero flag
//
// Modports:
//   master : the requester/consumer side (drives requests and Rsp_Ready)
//   slave  : the arbiter side
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  A_Valid;
    logic                  A_Ready;
    logic [DATA_WIDTH-1:0] A_SrcA;
    logic [DATA_WIDTH-1:0] A_SrcB;
    logic [2:0]            A_ALU_Control;

    logic                  B_Valid;
    logic                  B_Ready;
    logic [DATA_WIDTH-1:0] B_SrcA;
    logic [DATA_WIDTH-1:0] B_SrcB;
    logic [2:0]            B_ALU_Control;

    logic                  Rsp_Valid;
    logic                  Rsp_Ready;
    logic                  Rsp_Id;
    logic [DATA_WIDTH-1:0] Rsp_Result;
    logic                  Rsp_Zero;

    modport master (
        output A_Valid, A_SrcA, A_SrcB, A_ALU_Control,
        input  A_Ready,
        output B_Valid, B_SrcA, B_SrcB, B_ALU_Control,
        input  B_Ready,
        input  Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero,
        output Rsp_Ready
    );

    modport slave (
        input  A_Valid, A_SrcA, A_SrcB, A_ALU_Control,
        output A_Ready,
        input  B_Valid, B_SrcA, B_SrcB, B_ALU_Control,
        output B_Ready,
        output Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero,
        input  Rsp_Ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares a single ALU between two requesters (A = 0, B = 1). In IDLE the
//   arbiter grants one request round-robin, registers its operands, spends
//   one EXEC cycle computing, then holds the registered result in RESP until
//   the consumer takes it. One operation completes at most every 3 cycles.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   RST          synchronous active-high reset
//   bus          alu_share_arbiter_if.slave (request A/B, response port)
//   Busy         high whenever the FSM is not in IDLE
//   Grant_Cnt_A  accepted-request count for A (only with ALU_ARB_GRANT_CNT_EN)
//   Grant_Cnt_B  accepted-request count for B (only with ALU_ARB_GRANT_CNT_EN)
//
// Build option:
//   ALU_ARB_GRANT_CNT_EN  when defined, adds two free-running CNT_WIDTH-bit
//                         grant counters that wrap from all-ones to zero.
//
// ALU opcodes:
//   000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL (low half), 110 SLT (unsigned)
//   011 and 111 produce 0 (and therefore Zero = 1).
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    alu_share_arbiter_if.slave      bus,
`ifdef ALU_ARB_GRANT_CNT_EN
    output logic [CNT_WIDTH-1:0]    Grant_Cnt_A,
    output logic [CNT_WIDTH-1:0]    Grant_Cnt_B,
`endif
    output logic                    Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    // -----------------------------------------------------------------------
    // Requester view as index-able arrays so that grant logic and counters
    // can be written once for both requesters.
    // -----------------------------------------------------------------------
    logic [1:0]            req_valid;
    logic [DATA_WIDTH-1:0] req_src_a [2];
    logic [DATA_WIDTH-1:0] req_src_b [2];
    logic [2:0]            req_ctl   [2];

    assign req_valid[0] = bus.A_Valid;
    assign req_valid[1] = bus.B_Valid;
    assign req_src_a[0] = bus.A_SrcA;
    assign req_src_a[1] = bus.B_SrcA;
    assign req_src_b[0] = bus.A_SrcB;
    assign req_src_b[1] = bus.B_SrcB;
    assign req_ctl[0]   = bus.A_ALU_Control;
    assign req_ctl[1]   = bus.B_ALU_Control;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                state_reg,      state_next;
    logic                  ptr_reg,        ptr_next;     // preferred requester
    logic [DATA_WIDTH-1:0] op_a_reg,       op_a_next;
    logic [DATA_WIDTH-1:0] op_b_reg,       op_b_next;
    logic [2:0]            op_ctl_reg,     op_ctl_next;
    logic                  op_id_reg,      op_id_next;
    logic                  rsp_valid_reg,  rsp_valid_next;
    logic                  rsp_id_reg,     rsp_id_next;
    logic [DATA_WIDTH-1:0] rsp_result_reg, rsp_result_next;
    logic                  rsp_zero_reg,   rsp_zero_next;

    // -----------------------------------------------------------------------
    // Round-robin grant. A requester is granted in IDLE when it is valid and
    // either the other one is idle or the pointer currently favours it.
    // Ready is purely combinational from Valid and the pointer.
    // -----------------------------------------------------------------------
    logic [1:0] grant;
    logic       accept;
    logic       accept_id;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = (state_reg == IDLE) && req_valid[gi] &&
                               (!req_valid[1-gi] || (ptr_reg == 1'(gi)));
        end
    endgenerate

    assign accept    = |grant;
    assign accept_id = grant[1];

    assign bus.A_Ready = grant[0];
    assign bus.B_Ready = grant[1];

    // -----------------------------------------------------------------------
    // Shared ALU, purely combinational from the operand registers. It is only
    // observed during EXEC, when those registers hold the accepted operation.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;

    always_comb begin
        alu_result = '0;
        case (op_ctl_reg)
            OP_AND:  alu_result = op_a_reg & op_b_reg;
            OP_OR:   alu_result = op_a_reg | op_b_reg;
            OP_ADD:  alu_result = op_a_reg + op_b_reg;
            OP_SUB:  alu_result = op_a_reg - op_b_reg;
            OP_MUL:  alu_result = op_a_reg * op_b_reg;   // low half kept
            OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, (op_a_reg < op_b_reg)};
            default: alu_result = '0;                    // 011 / 111
        endcase
    end

    assign alu_zero = (alu_result == '0);

    // -----------------------------------------------------------------------
    // FSM next-state and datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        op_a_next       = op_a_reg;
        op_b_next       = op_b_reg;
        op_ctl_next     = op_ctl_reg;
        op_id_next      = op_id_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_id_next     = rsp_id_reg;
        rsp_result_next = rsp_result_reg;
        rsp_zero_next   = rsp_zero_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_a_next   = req_src_a[accept_id];
                    op_b_next   = req_src_b[accept_id];
                    op_ctl_next = req_ctl[accept_id];
                    op_id_next  = accept_id;
                    // The winner becomes the less preferred requester.
                    ptr_next    = ~accept_id;
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_next = alu_result;
                rsp_zero_next   = alu_zero;
                rsp_id_next     = op_id_reg;
                rsp_valid_next  = 1'b1;
                state_next      = RESP;
            end
            RESP: begin
                // Result fields stay as they are after the handshake; only
                // the valid flag drops.
                if (bus.Rsp_Ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                rsp_valid_next = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            ptr_reg        <= 1'b0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            op_ctl_reg     <= '0;
            op_id_reg      <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            op_a_reg       <= op_a_next;
            op_b_reg       <= op_b_next;
            op_ctl_reg     <= op_ctl_next;
            op_id_reg      <= op_id_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_result_reg <= rsp_result_next;
            rsp_zero_reg   <= rsp_zero_next;
        end
    end

    assign bus.Rsp_Valid  = rsp_valid_reg;
    assign bus.Rsp_Id     = rsp_id_reg;
    assign bus.Rsp_Result = rsp_result_reg;
    assign bus.Rsp_Zero   = rsp_zero_reg;
    assign Busy           = (state_reg != IDLE);

`ifdef ALU_ARB_GRANT_CNT_EN
    // -----------------------------------------------------------------------
    // Grant counters: one per requester, bumped on the accept edge so the
    // new count is visible in the cycle after the accept. Plain wrap-around.
    // -----------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] grant_cnt_reg [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant_cnt
            always_ff @(posedge CLK) begin
                if (RST) begin
                    grant_cnt_reg[gi] <= '0;
                end else if (grant[gi]) begin
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign Grant_Cnt_A = grant_cnt_reg[0];
    assign Grant_Cnt_B = grant_cnt_reg[1];
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter. Stimulus pushes the expected
// response of every accepted request into a queue; an independent monitor
// pops and compares whenever a response handshake happens. Inputs change on
// the falling edge, outputs are sampled shortly after it.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int DW = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_R3  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_R7  = 3'b111;

    logic CLK = 1'b0;
    logic RST;
    logic Busy;

    always #5 CLK = ~CLK;

    alu_share_arbiter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef ALU_ARB_GRANT_CNT_EN
    localparam int CW = 4;
    logic [CW-1:0] Grant_Cnt_A;
    logic [CW-1:0] Grant_Cnt_B;

    alu_share_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus),
        .Grant_Cnt_A (Grant_Cnt_A),
        .Grant_Cnt_B (Grant_Cnt_B),
        .Busy        (Busy)
    );
`else
    alu_share_arbiter #(.DATA_WIDTH(DW)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .Busy (Busy)
    );
`endif

    typedef struct packed {
        logic          id;
        logic [DW-1:0] result;
        logic          zero;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic id, input logic [DW-1:0] res, input logic z);
        rsp_t e;
        e.id     = id;
        e.result = res;
        e.zero   = z;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic id, input logic v, input logic [2:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (!id) begin
            bus.A_Valid = v; bus.A_ALU_Control = op; bus.A_SrcA = a; bus.A_SrcB = b;
        end else begin
            bus.B_Valid = v; bus.B_ALU_Control = op; bus.B_SrcA = a; bus.B_SrcB = b;
        end
    endtask

    // Wait (bounded) until every expected response has been consumed.
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // One complete transaction with the consumer always ready.
    task automatic issue(input logic id, input logic [2:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] res, input logic z);
        int n = 0;
        @(negedge CLK);
        bus.Rsp_Ready = 1'b1;
        drive(id, 1'b1, op, a, b);
        #1;
        while (!(id ? bus.B_Ready : bus.A_Ready) && n < 10) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("issue_accept", 64'(n < 10), 64'd1);
        $display("req id=%0d op=%03b a=0x%0h b=0x%0h", id, op, a, b);
        push_exp(id, res, z);
        @(negedge CLK);
        drive(id, 1'b0, 3'b000, '0, '0);
        wait_drain("issue_drain");
    endtask

    // Response monitor / scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (bus.Rsp_Valid === 1'b1 && bus.Rsp_Ready === 1'b1) begin
                rsp_t e;
                $display("rsp id=%0d result=0x%0h zero=%0d", bus.Rsp_Id, bus.Rsp_Result, bus.Rsp_Zero);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got id=%0d result=0x%0h, expected no response",
                             bus.Rsp_Id, bus.Rsp_Result);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(bus.Rsp_Id), 64'(e.id));
                    chk("rsp_result", 64'(bus.Rsp_Result), 64'(e.result));
                    chk("rsp_zero", 64'(bus.Rsp_Zero), 64'(e.zero));
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        RST = 1'b1;
        bus.Rsp_Ready = 1'b0;
        drive(1'b0, 1'b0, 3'b000, '0, '0);
        drive(1'b1, 1'b0, 3'b000, '0, '0);

        // ---------------- reset and idle ----------------
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(bus.Rsp_Valid), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_a_ready", 64'(bus.A_Ready), 64'd0);
        chk("rst_b_ready", 64'(bus.B_Ready), 64'd0);
        chk("rst_rsp_result", 64'(bus.Rsp_Result), 64'd0);
        chk("rst_rsp_id", 64'(bus.Rsp_Id), 64'd0);
        chk("rst_rsp_zero", 64'(bus.Rsp_Zero), 64'd0);

        // ---------------- single op, latency ----------------
        @(negedge CLK);
        drive(1'b0, 1'b1, OP_SUB, 32'd7, 32'd5);
        #1;
        chk("single_a_ready", 64'(bus.A_Ready), 64'd1);
        chk("single_b_ready", 64'(bus.B_Ready), 64'd0);
        $display("req id=0 op=100 a=0x7 b=0x5");
        push_exp(1'b0, 32'd2, 1'b0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 3'b000, '0, '0);
        #1;
        chk("single_exec_busy", 64'(Busy), 64'd1);
        chk("single_exec_valid", 64'(bus.Rsp_Valid), 64'd0);
        chk("single_exec_ready", 64'(bus.A_Ready), 64'd0);
        @(negedge CLK);
        #1;
        chk("single_n2_valid", 64'(bus.Rsp_Valid), 64'd1);
        chk("single_n2_result", 64'(bus.Rsp_Result), 64'd2);
        @(negedge CLK);
        bus.Rsp_Ready = 1'b1;
        @(negedge CLK);
        bus.Rsp_Ready = 1'b0;
        #1;
        chk("single_after_valid", 64'(bus.Rsp_Valid), 64'd0);
        chk("single_after_busy", 64'(Busy), 64'd0);
        chk("single_hold_result", 64'(bus.Rsp_Result), 64'd2);
        chk("single_drain", 64'(exp_q.size()), 64'd0);

        // ---------------- reset mid-operation ----------------
        // Pointer currently favours B; after reset it must favour A again.
        @(negedge CLK);
        drive(1'b0, 1'b1, OP_OR, 32'hF0, 32'h0F);
        #1;
        chk("rstmid_accept", 64'(bus.A_Ready), 64'd1);
        $display("req id=0 op=001 a=0xf0 b=0xf (discarded by reset)");
        @(negedge CLK);
        drive(1'b0, 1'b0, 3'b000, '0, '0);
        RST = 1'b1;
        #1;
        chk("rstmid_exec_busy", 64'(Busy), 64'd1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rstmid_valid", 64'(bus.Rsp_Valid), 64'd0);
        chk("rstmid_busy", 64'(Busy), 64'd0);
        chk("rstmid_result", 64'(bus.Rsp_Result), 64'd0);
        repeat (3) begin
            @(negedge CLK);
            #1;
            chk("rstmid_no_rsp", 64'(bus.Rsp_Valid), 64'd0);
        end

        // ---------------- contention, A then B alternating ----------------
        @(negedge CLK);
        bus.Rsp_Ready = 1'b1;
        drive(1'b0, 1'b1, OP_ADD, 32'd3, 32'd4);
        drive(1'b1, 1'b1, OP_SUB, 32'd9, 32'd9);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            if (c % 3 == 0) begin
                logic eid;
                eid = 1'((c / 3) % 2);
                chk("cont_grant_a", 64'(bus.A_Ready), 64'(!eid));
                chk("cont_grant_b", 64'(bus.B_Ready), 64'(eid));
                $display("req id=%0d (contention slot %0d)", eid, c / 3);
                if (!eid) push_exp(1'b0, 32'd7, 1'b0);
                else      push_exp(1'b1, 32'd0, 1'b1);
            end else begin
                chk("cont_gap_ready", 64'({bus.A_Ready, bus.B_Ready}), 64'd0);
            end
        end
        @(negedge CLK);
        drive(1'b0, 1'b0, 3'b000, '0, '0);
        drive(1'b1, 1'b0, 3'b000, '0, '0);
        wait_drain("cont_drain");

        // ---------------- backpressure ----------------
        @(negedge CLK);
        bus.Rsp_Ready = 1'b0;
        drive(1'b1, 1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0000);
        #1;
        chk("bp_b_ready", 64'(bus.B_Ready), 64'd1);
        $display("req id=1 op=101 a=0x10000 b=0x10000");
        push_exp(1'b1, 32'd0, 1'b1);
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'b000, '0, '0);
        drive(1'b0, 1'b1, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        #1;
        chk("bp_exec_a_ready", 64'(bus.A_Ready), 64'd0);
        repeat (6) begin
            @(negedge CLK);
            #1;
            chk("bp_hold_valid", 64'(bus.Rsp_Valid), 64'd1);
            chk("bp_hold_result", 64'(bus.Rsp_Result), 64'd0);
            chk("bp_hold_ready", 64'({bus.A_Ready, bus.B_Ready}), 64'd0);
        end
        @(negedge CLK);
        bus.Rsp_Ready = 1'b1;
        #1;
        chk("bp_release_valid", 64'(bus.Rsp_Valid), 64'd1);
        @(negedge CLK);
        #1;
        chk("bp_next_grant", 64'(bus.A_Ready), 64'd1);
        chk("bp_next_valid", 64'(bus.Rsp_Valid), 64'd0);
        $display("req id=0 op=000 a=0xff00ff00 b=0xff00ff0");
        push_exp(1'b0, 32'h0F00_0F00, 1'b0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 3'b000, '0, '0);
        wait_drain("bp_drain");

        // ---------------- opcode vectors ----------------
        issue(1'b0, OP_OR,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0);
        issue(1'b1, OP_SLT, 32'd3,         32'd5,         32'd1,         1'b0);
        issue(1'b0, OP_SLT, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1);
        issue(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1);
        issue(1'b0, OP_R3,  32'h1234_5678, 32'h1,         32'd0,         1'b1);
        issue(1'b1, OP_R7,  32'hDEAD_BEEF, 32'h5,         32'd0,         1'b1);
        issue(1'b0, OP_MUL, 32'd1000,      32'd3000,      32'd3000000,   1'b0);
        issue(1'b1, OP_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0);

`ifdef ALU_ARB_GRANT_CNT_EN
        // ---------------- grant counters (4-bit) ----------------
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("cnt_rst_a", 64'(Grant_Cnt_A), 64'd0);
        chk("cnt_rst_b", 64'(Grant_Cnt_B), 64'd0);
        for (int i = 0; i < 17; i++) begin
            issue(1'b0, OP_ADD, 32'(i), 32'd1, 32'(i + 1), 1'b0);
        end
        #1;
        chk("cnt_wrap_a", 64'(Grant_Cnt_A), 64'd1);
        chk("cnt_wrap_b", 64'(Grant_Cnt_B), 64'd0);
`endif

        repeat (3) @(negedge CLK);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
